// File: rtl/arbitro_pkg.sv
// Shared types and default sizing for the round-robin selection arbiter.
package arbitro_pkg;
  localparam int N_DEF        = 8;
  localparam int W_DEF        = 4;
  localparam int MAX_HOLD_DEF = 4;
  localparam int IW           = $clog2(N_DEF);
  localparam int CW           = $clog2(MAX_HOLD_DEF + 1);

  typedef enum logic {OCIOSO, CONCEDIDO} estado_t;
endpackage

// File: rtl/seletor_rr.sv
// Rotating-priority picker: first set request found scanning from ptr upward, wrapping mod N.
module seletor_rr #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] winner,
  output logic          any
);

  logic [SW-1:0] idx;

  // Scan farthest-first so the closest request to ptr is the last to overwrite winner.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr + SW'(k);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_simulador.sv
// Round-robin arbiter for the shared N:1 selection datapath with valid/ready output
// and a per-grant transfer cap that forces rotation.
//
//  state     | meaning
//  OCIOSO    | no grant; GNT=0, SEL/ORIGEM keep last value, waiting for any REQ
//  CONCEDIDO | SEL granted; VALIDO follows REQ[SEL], transfers counted in cont
module arbitro_simulador
  import arbitro_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int W        = W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic [N-1:0]          REQ,
  input  logic [N-1:0][W-1:0]   DADOS,
  input  logic                  PRONTO,
  output logic                  VALIDO,
  output logic [W-1:0]          SAIDA,
  output logic [$clog2(N)-1:0]  SEL,
  output logic [$clog2(N)-1:0]  ORIGEM,
  output logic [N-1:0]          GNT
);

  localparam int SW = $clog2(N);
  localparam int KW = $clog2(MAX_HOLD + 1);
  localparam logic [KW-1:0] CONT_ULT = KW'(MAX_HOLD - 1);
  localparam logic [N-1:0]  GNT_UM   = {{(N - 1){1'b0}}, 1'b1};

  estado_t       estado;
  logic [SW-1:0] ptr;
  logic [SW-1:0] sel;
  logic [KW-1:0] cont;
  logic [N-1:0]  gnt;

  logic [SW-1:0] scan_ini;
  logic [SW-1:0] winner;
  logic          any;
  logic          transfer;
  logic          liberar;

  // Idle scans from ptr; a release scans from SEL+1, which is the ptr it is about to load.
  assign scan_ini = (estado == CONCEDIDO) ? sel + 1'b1 : ptr;

  seletor_rr #(.N(N), .SW(SW)) u_seletor (
    .req    (REQ),
    .ptr    (scan_ini),
    .winner (winner),
    .any    (any)
  );

  assign VALIDO   = (estado == CONCEDIDO) && REQ[sel];
  assign transfer = VALIDO && PRONTO;
  assign liberar  = (estado == CONCEDIDO) && (!REQ[sel] || (transfer && cont == CONT_ULT));

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      estado <= OCIOSO;
      ptr    <= '0;
      sel    <= '0;
      cont   <= '0;
      gnt    <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (any) begin
            sel    <= winner;
            gnt    <= GNT_UM << winner;
            cont   <= '0;
            estado <= CONCEDIDO;
          end
        end
        CONCEDIDO: begin
          if (liberar) begin
            ptr  <= sel + 1'b1;
            cont <= '0;
            if (any) begin
              sel <= winner;
              gnt <= GNT_UM << winner;
            end else begin
              gnt    <= '0;
              estado <= OCIOSO;
            end
          end else if (transfer) begin
            cont <= cont + 1'b1;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign SEL    = sel;
  assign ORIGEM = sel;
  assign GNT    = gnt;
  assign SAIDA  = VALIDO ? DADOS[sel] : '0;

endmodule

// File: tb/tb_arbitro_simulador.sv
// Self-checking bench for arbitro_simulador: directed scenarios plus random traffic
// compared every cycle against a behavioural round-robin model.
module tb_arbitro_simulador;
  localparam int N        = 8;
  localparam int W        = 4;
  localparam int MAX_HOLD = 4;

  logic                clock;
  logic                nreset;
  logic [N-1:0]        req;
  logic [N-1:0][W-1:0] dados;
  logic                pronto;
  logic                valido;
  logic [W-1:0]        saida;
  logic [2:0]          sel;
  logic [2:0]          origem;
  logic [N-1:0]        gnt;

  int checks = 0;
  int errors = 0;

  // model: who holds the grant, how many transfers it has made, where the scan resumes
  bit m_conc;
  int m_sel;
  int m_ptr;
  int m_cont;

  arbitro_simulador #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clock  (clock),
    .nreset (nreset),
    .REQ    (req),
    .DADOS  (dados),
    .PRONTO (pronto),
    .VALIDO (valido),
    .SAIDA  (saida),
    .SEL    (sel),
    .ORIGEM (origem),
    .GNT    (gnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_conc = 1'b0;
    m_sel  = 0;
    m_ptr  = 0;
    m_cont = 0;
  endtask

  task automatic model_step();
    int  w;
    bit  xfer;
    if (!m_conc) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_conc = 1'b1;
        m_sel  = w;
        m_cont = 0;
      end
    end else begin
      xfer = req[m_sel] && pronto;
      if (!req[m_sel] || (xfer && m_cont + 1 == MAX_HOLD)) begin
        m_ptr  = (m_sel + 1) % N;
        m_cont = 0;
        w = pick(req, m_ptr);
        if (w >= 0) m_sel = w;
        else m_conc = 1'b0;
      end else if (xfer) begin
        m_cont++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] e_gnt;
    logic         e_vld;
    logic [W-1:0] e_sai;
    e_gnt = m_conc ? (N'(1) << m_sel) : '0;
    e_vld = m_conc && req[m_sel];
    e_sai = e_vld ? dados[m_sel] : '0;
    chk_eq({tag, "_gnt"}, gnt, e_gnt);
    chk_eq({tag, "_vld"}, valido, e_vld);
    chk_eq({tag, "_sai"}, saida, e_sai);
    chk_eq({tag, "_sel"}, sel, m_sel);
    chk_eq({tag, "_org"}, origem, m_sel);
  endtask

  // Entered just after a rising edge with inputs already applied.
  task automatic cycle(input string tag);
    #1;
    check_model(tag);
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    #1;
    model_reset();
    chk_eq("rst_gnt", gnt, '0);
    chk_eq("rst_vld", valido, 1'b0);
    nreset = 1'b1;
  endtask

  int xfers;
  int exp_org [12] = '{2, 2, 2, 2, 5, 5, 5, 5, 2, 2, 2, 2};

  initial begin
    nreset = 1'b0;
    req    = 8'hFF;
    pronto = 1'b1;
    for (int i = 0; i < N; i++) dados[i] = W'(i + 3);
    model_reset();

    // 1 reset with all requests pending
    #2;
    chk_eq("t1_gnt", gnt, 8'h00);
    chk_eq("t1_vld", valido, 1'b0);
    chk_eq("t1_sel", sel, 3'd0);
    chk_eq("t1_sai", saida, 4'h0);
    @(posedge clock);
    #1;
    nreset = 1'b1;
    cycle("t1");
    chk_eq("t1_gnt_after", gnt, 8'h01);

    // 2 rotation between idx 2 and 5, no idle bubble
    @(posedge clock);
    #1;
    do_reset();
    req = 8'b0010_0100;
    pronto = 1'b1;
    cycle("t2");
    for (int k = 0; k < 12; k++) begin
      #1;
      chk_eq("t2_org", origem, exp_org[k]);
      chk_eq("t2_vld", valido, 1'b1);
      #0;
      check_model("t2");
      model_step();
      @(posedge clock);
      #1;
    end

    // 3 early drop of idx 3 after one transfer
    do_reset();
    req = 8'h08;
    cycle("t3");
    chk_eq("t3_gnt3", gnt, 8'h08);
    cycle("t3");
    req = 8'h40;
    #1;
    chk_eq("t3_vld_drop", valido, 1'b0);
    check_model("t3");
    model_step();
    @(posedge clock);
    #1;
    chk_eq("t3_gnt6", gnt, 8'h40);
    chk_eq("t3_org6", origem, 3'd6);

    // 4 backpressure on idx 1 then exactly MAX_HOLD transfers
    do_reset();
    req = 8'h02;
    dados[1] = 4'hA;
    pronto = 1'b0;
    cycle("t4");
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_eq("t4_hold_gnt", gnt, 8'h02);
      chk_eq("t4_hold_sai", saida, 4'hA);
      cycle("t4");
    end
    pronto = 1'b1;
    xfers = 0;
    for (int k = 0; k < MAX_HOLD; k++) begin
      #1;
      if (valido && pronto) xfers++;
      cycle("t4");
    end
    chk_eq("t4_xfers", xfers, MAX_HOLD);
    chk_eq("t4_regrant", gnt, 8'h02);

    // 5 sole requester at idx 7, wrapping ptr; then idx 0 joins
    do_reset();
    req = 8'h80;
    pronto = 1'b1;
    cycle("t5");
    for (int k = 0; k < 3 * MAX_HOLD; k++) begin
      #1;
      chk_eq("t5_gnt7", gnt, 8'h80);
      chk_eq("t5_vld", valido, 1'b1);
      cycle("t5");
    end
    req = 8'h81;
    for (int k = 0; k < 2 * MAX_HOLD; k++) cycle("t5b");

    // 6 async reset in the middle of a grant
    req = 8'hFF;
    cycle("t6");
    cycle("t6");
    nreset = 1'b0;
    #1;
    chk_eq("t6_gnt_clr", gnt, 8'h00);
    chk_eq("t6_vld_clr", valido, 1'b0);
    model_reset();
    #1;
    nreset = 1'b1;
    cycle("t6");
    chk_eq("t6_restart", gnt, 8'h01);

    // random traffic: sparse requests, random ready and data, occasional stable stretches
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) != 0) begin
        for (int i = 0; i < N; i++) req[i] = ($urandom_range(9) < 4);
      end
      pronto = ($urandom_range(3) != 0);
      for (int i = 0; i < N; i++) dados[i] = W'($urandom);
      if ($urandom_range(199) == 0) begin
        nreset = 1'b0;
        #1;
        chk_eq("rnd_rst_gnt", gnt, 8'h00);
        model_reset();
        nreset = 1'b1;
      end
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
